wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WB_ALU, default 2'd0, meaning wbsel code selecting ALU result.
REQ-002 SHALL have parameter WB_MEM, default 2'd1, meaning wbsel code selecting load data.
REQ-003 SHALL have parameter WB_LINK, default 2'd2, meaning wbsel code selecting PC+8 link value.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 stall  in  1  hold MEM/WB register contents.
REQ-007 flush  in  1  load a bubble into MEM/WB register.
REQ-008 m_valid  in  1  MEM-stage instruction valid.
REQ-009 m_regwr  in  1  instruction writes a GPR.
REQ-010 m_dst  in  5  destination register number.
REQ-011 m_wbsel  in  2  result source code.
REQ-012 m_ldtype  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 reserved.
REQ-013 m_addr_lo  in  2  load address bits [1:0].
REQ-014 m_alu_res, m_mem_rdata, m_pc8  in  32 each  ALU result, raw memory word, link value.
REQ-015 RegWrDst_W  out  5  register-file write address.
REQ-016 wd  out  32  register-file write data.
REQ-017 wr  out  1  register-file write enable.
REQ-018 w_valid  out  1  WB stage holds a valid instruction.
REQ-019 w_misalign  out  1  held load is misaligned.
REQ-020 retired  out  32  count of retired instructions.

Function
REQ-021 Per edge, priority: !rst_n, then flush (w_valid<=0, other fields don't-care), then stall (hold all), else capture all m_* fields.
REQ-022 All of RegWrDst_W, wd, wr, w_misalign SHALL be combinational from the MEM/WB register only (one-cycle latency from m_* to outputs, no m_* combinational path).
REQ-023 wr = w_valid & regwr & (dst != 0) & !w_misalign; RegWrDst_W = held dst.
REQ-024 Load extraction little-endian: LB/LBU byte = word[8*addr_lo +: 8], sign/zero-extended; LH/LHU half = word[16*addr_lo[1] +: 16], sign/zero-extended; LW full word.
REQ-025 w_misalign = w_valid & wbsel==WB_MEM & ((LH|LHU) & addr_lo[0] | LW & addr_lo!=0).
REQ-026 wd = alu_res for WB_ALU, extracted load for WB_MEM, pc8 for WB_LINK; wbsel 2'd3 or reserved ldtype SHALL force wr=0 and wd=0.
REQ-027 retired SHALL increment by 1 on each edge where w_valid=1 and stall=0 (instruction leaves stage), including misaligned and non-writing instructions; wraps 32'hFFFFFFFF->0.
REQ-028 stall=1 holds wr high for repeated cycles; repeated identical writes are permitted and retired SHALL NOT increment.
REQ-029 flush and stall together: flush wins; retired still increments if w_valid was 1.

Reset
REQ-030 On posedge clk with rst_n=0: w_valid=0, retired=0, all held fields 0; hence wr=0, wd=0, RegWrDst_W=0, w_misalign=0 from the next cycle.
REQ-031 Reset mid-stall or mid-flush SHALL take priority; no increment of retired on the reset edge.

Structure
REQ-032 WB_* select codes and LD_* load-type codes SHALL live in shared package cpu_pkg, reused by the decoder.
REQ-033 Load extraction SHALL be a sub-module load_align (combinational: word, addr_lo, ldtype -> data, misalign).

Verification
REQ-034 ALU write: m_valid=1, regwr=1, dst=8, wbsel=ALU, alu_res=32'h1234 -> next cycle wr=1, RegWrDst_W=8, wd=32'h1234, retired 0->1 at following edge.
REQ-035 Load sign: rdata=32'h80FF7F01, LB addr_lo=3 -> wd=32'hFFFFFF80; LBU addr_lo=1 -> 32'h0000007F; LH addr_lo=2 -> 32'hFFFF80FF; LHU addr_lo=0 -> 32'h00007F01.
REQ-036 Misalign: LW addr_lo=2, dst=5 -> wr=0, w_misalign=1, retired still increments.
REQ-037 $zero: dst=0, regwr=1, alu_res=32'hDEAD -> wr=0.
REQ-038 Stall 3 cycles holding a JAL (dst=31, pc8=32'h00400008) -> wr=1, wd=32'h00400008 constant for 3 cycles, retired unchanged until stall drops; then flush+stall same cycle -> w_valid=0 next cycle.
REQ-039 Assert rst_n=0 while stall=1 and w_valid=1 -> next cycle w_valid=0, wr=0, retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared write-back select codes, load-type codes and MEM/WB register layout
package cpu_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic [4:0]  dst;
        logic [1:0]  wbsel;
        logic [2:0]  ldtype;
        logic [1:0]  addr_lo;
        logic [31:0] alu_res;
        logic [31:0] mem_rdata;
        logic [31:0] pc8;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-stage result bundle in, register-file write port out
interface wb_stage_if;
    logic        m_valid;
    logic        m_regwr;
    logic [4:0]  m_dst;
    logic [1:0]  m_wbsel;
    logic [2:0]  m_ldtype;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu_res;
    logic [31:0] m_mem_rdata;
    logic [31:0] m_pc8;
    logic [4:0]  RegWrDst_W;
    logic [31:0] wd;
    logic        wr;

    modport master (
        output m_valid, m_regwr, m_dst, m_wbsel, m_ldtype, m_addr_lo,
               m_alu_res, m_mem_rdata, m_pc8,
        input  RegWrDst_W, wd, wr
    );

    modport slave (
        input  m_valid, m_regwr, m_dst, m_wbsel, m_ldtype, m_addr_lo,
               m_alu_res, m_mem_rdata, m_pc8,
        output RegWrDst_W, wd, wr
    );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian load extraction with sign/zero extension and alignment check
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ldtype,
    output logic [31:0] o_data,
    output logic        o_misalign,
    output logic        o_bad_type
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        o_bad_type = 1'b0;
        case (i_ldtype)
            LD_LW: begin
                o_data     = i_word;
                o_misalign = (i_addr_lo != 2'd0);
            end
            LD_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            LD_LHU: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_addr_lo[0];
            end
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'h000000, w_byte};
            default: o_bad_type = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, result select and retired-instruction counter
module wb_stage #(
    parameter logic [1:0] WB_ALU  = cpu_pkg::WB_ALU,
    parameter logic [1:0] WB_MEM  = cpu_pkg::WB_MEM,
    parameter logic [1:0] WB_LINK = cpu_pkg::WB_LINK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    wb_stage_if.slave   bus,
    output logic        w_valid,
    output logic        w_misalign,
    output logic [31:0] retired
);
    import cpu_pkg::mem_wb_t;

    mem_wb_t     r_mw;
    logic [31:0] r_retired;
    mem_wb_t     w_next;
    logic [31:0] w_load;
    logic        w_ld_misalign;
    logic        w_bad_type;
    logic [31:0] w_sel_data;
    logic        w_bad_sel;
    logic        w_bad;

    assign w_next = '{valid:     bus.m_valid,
                      regwr:     bus.m_regwr,
                      dst:       bus.m_dst,
                      wbsel:     bus.m_wbsel,
                      ldtype:    bus.m_ldtype,
                      addr_lo:   bus.m_addr_lo,
                      alu_res:   bus.m_alu_res,
                      mem_rdata: bus.m_mem_rdata,
                      pc8:       bus.m_pc8};

    // An instruction leaves the stage when it is not held, or when a flush discards it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mw      <= '0;
            r_retired <= '0;
        end else begin
            if (r_mw.valid && (!stall || flush))
                r_retired <= r_retired + 32'd1;
            if (flush)
                r_mw.valid <= 1'b0;
            else if (!stall)
                r_mw <= w_next;
        end
    end

    load_align u_load_align (
        .i_word     (r_mw.mem_rdata),
        .i_addr_lo  (r_mw.addr_lo),
        .i_ldtype   (r_mw.ldtype),
        .o_data     (w_load),
        .o_misalign (w_ld_misalign),
        .o_bad_type (w_bad_type)
    );

    always_comb begin
        w_sel_data = '0;
        w_bad_sel  = 1'b0;
        if (r_mw.wbsel == WB_ALU)
            w_sel_data = r_mw.alu_res;
        else if (r_mw.wbsel == WB_MEM)
            w_sel_data = w_load;
        else if (r_mw.wbsel == WB_LINK)
            w_sel_data = r_mw.pc8;
        else
            w_bad_sel = 1'b1;
    end

    // Unknown select or reserved load type suppresses the write entirely.
    assign w_bad          = w_bad_sel | w_bad_type;
    assign w_valid        = r_mw.valid;
    assign w_misalign     = r_mw.valid & (r_mw.wbsel == WB_MEM) & w_ld_misalign;
    assign retired        = r_retired;
    assign bus.RegWrDst_W = r_mw.dst;
    assign bus.wd         = w_bad ? 32'h0 : w_sel_data;
    assign bus.wr         = r_mw.valid & r_mw.regwr & (r_mw.dst != 5'd0)
                            & ~w_misalign & ~w_bad;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage write-back, load extraction, stall/flush and retire count
module tb_wb_stage;

    typedef struct {
        logic        wr;
        logic [4:0]  dst;
        logic [31:0] wd;
        logic        mis;
    } exp_t;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        w_valid;
    logic        w_misalign;
    logic [31:0] retired;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic        mv;
    logic [31:0] exp_ret;

    wb_stage_if u_if ();

    wb_stage u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .bus        (u_if),
        .w_valid    (w_valid),
        .w_misalign (w_misalign),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rw, input logic [4:0] dst,
                         input logic [1:0] sel, input logic [2:0] ld, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc8);
        u_if.m_valid     = v;
        u_if.m_regwr     = rw;
        u_if.m_dst       = dst;
        u_if.m_wbsel     = sel;
        u_if.m_ldtype    = ld;
        u_if.m_addr_lo   = lo;
        u_if.m_alu_res   = alu;
        u_if.m_mem_rdata = rd;
        u_if.m_pc8       = pc8;
    endtask

    // Reference model of valid bit and retire count, advanced alongside every clock edge.
    task automatic tick();
        if (!rst_n) begin
            mv      = 1'b0;
            exp_ret = 32'd0;
        end else begin
            if (mv && (!stall || flush)) exp_ret = exp_ret + 32'd1;
            if (flush)       mv = 1'b0;
            else if (!stall) mv = u_if.m_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 5'd3, SEL_ALU, 3'd0, 2'd0, 32'hFFFF_0000, 32'h1, 32'h2);
        tick();
        tick();
        total++;
        if ({w_valid, u_if.wr, u_if.RegWrDst_W, u_if.wd, w_misalign, retired} !== 71'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b wr=%b dst=%0d wd=%h mis=%b ret=%0d exp all zero",
                     w_valid, u_if.wr, u_if.RegWrDst_W, u_if.wd, w_misalign, retired);
        end
        rst_n = 1'b1;
        drive(0, 0, 5'd0, SEL_ALU, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_alu();
        exp_t e;
        drive(1, 1, 5'd8, SEL_ALU, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0);
        sb.push_back('{1'b1, 5'd8, 32'h1234, 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if ({u_if.wr, u_if.RegWrDst_W, u_if.wd, w_misalign, w_valid} !== {e.wr, e.dst, e.wd, e.mis, 1'b1}) begin
            bad++;
            $display("FAIL alu_write got wr=%b dst=%0d wd=%h exp wr=%b dst=%0d wd=%h",
                     u_if.wr, u_if.RegWrDst_W, u_if.wd, e.wr, e.dst, e.wd);
        end
        total++;
        if (retired !== 32'd0) begin
            bad++;
            $display("FAIL alu_retired_before got=%0d exp=0", retired);
        end
        drive(0, 0, 5'd0, SEL_ALU, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
        total++;
        if (retired !== 32'd1) begin
            bad++;
            $display("FAIL alu_retired_after got=%0d exp=1", retired);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lds [6]  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3};
        logic [1:0]  los [6]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                                  32'h00007F01, 32'h80FF7F01, 32'h00000001};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 5'(10 + i), SEL_MEM, lds[i], los[i], 32'hBAD0BAD0, 32'h80FF7F01, 32'h0);
            sb.push_back('{1'b1, 5'(10 + i), exps[i], 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if ({u_if.wr, u_if.RegWrDst_W, u_if.wd, w_misalign} !== {e.wr, e.dst, e.wd, e.mis}) begin
                bad++;
                $display("FAIL load_%0d got wr=%b dst=%0d wd=%h mis=%b exp wr=%b dst=%0d wd=%h mis=%b",
                         i, u_if.wr, u_if.RegWrDst_W, u_if.wd, w_misalign, e.wr, e.dst, e.wd, e.mis);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0] lds [3] = '{3'd0, 3'd1, 3'd2};
        logic [1:0] los [3] = '{2'd2, 2'd1, 2'd3};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd5, SEL_MEM, lds[i], los[i], 32'h0, 32'h12345678, 32'h0);
            sb.push_back('{1'b0, 5'd5, 32'h0, 1'b1});
            tick();
            e = sb.pop_front();
            total++;
            if ({u_if.wr, u_if.RegWrDst_W, w_misalign} !== {e.wr, e.dst, e.mis}) begin
                bad++;
                $display("FAIL misalign_%0d got wr=%b dst=%0d mis=%b exp wr=%b dst=%0d mis=%b",
                         i, u_if.wr, u_if.RegWrDst_W, w_misalign, e.wr, e.dst, e.mis);
            end
            total++;
            if (retired !== exp_ret) begin
                bad++;
                $display("FAIL misalign_retired_%0d got=%0d exp=%0d", i, retired, exp_ret);
            end
        end
    endtask

    task automatic test_zero_and_bad();
        exp_t e;
        drive(1, 1, 5'd0, SEL_ALU, 3'd0, 2'd0, 32'hDEAD, 32'h0, 32'h0);
        sb.push_back('{1'b0, 5'd0, 32'hDEAD, 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if ({u_if.wr, u_if.wd} !== {e.wr, e.wd}) begin
            bad++;
            $display("FAIL zero_dst got wr=%b wd=%h exp wr=%b wd=%h", u_if.wr, u_if.wd, e.wr, e.wd);
        end
        drive(1, 1, 5'd7, 2'd3, 3'd0, 2'd0, 32'hCAFE, 32'hF00D, 32'h44);
        sb.push_back('{1'b0, 5'd7, 32'h0, 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if ({u_if.wr, u_if.wd} !== {e.wr, e.wd}) begin
            bad++;
            $display("FAIL bad_wbsel got wr=%b wd=%h exp wr=%b wd=%h", u_if.wr, u_if.wd, e.wr, e.wd);
        end
        drive(1, 1, 5'd7, SEL_MEM, 3'd5, 2'd0, 32'hCAFE, 32'hF00D, 32'h44);
        sb.push_back('{1'b0, 5'd7, 32'h0, 1'b0});
        tick();
        e = sb.pop_front();
        total++;
        if ({u_if.wr, u_if.wd, w_misalign} !== {e.wr, e.wd, e.mis}) begin
            bad++;
            $display("FAIL bad_ldtype got wr=%b wd=%h mis=%b exp wr=%b wd=%h mis=%b",
                     u_if.wr, u_if.wd, w_misalign, e.wr, e.wd, e.mis);
        end
    endtask

    task automatic test_stall_jal();
        exp_t        e;
        logic [31:0] ret_hold;
        drive(1, 1, 5'd31, SEL_LINK, 3'd0, 2'd0, 32'hAAAA, 32'h0, 32'h00400008);
        tick();
        ret_hold = retired;
        stall = 1'b1;
        drive(1, 1, 5'd4, SEL_ALU, 3'd0, 2'd0, 32'h5555, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1'b1, 5'd31, 32'h00400008, 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if ({u_if.wr, u_if.RegWrDst_W, u_if.wd} !== {e.wr, e.dst, e.wd}) begin
                bad++;
                $display("FAIL stall_hold_%0d got wr=%b dst=%0d wd=%h exp wr=%b dst=%0d wd=%h",
                         i, u_if.wr, u_if.RegWrDst_W, u_if.wd, e.wr, e.dst, e.wd);
            end
            total++;
            if (retired !== ret_hold) begin
                bad++;
                $display("FAIL stall_retired_%0d got=%0d exp=%0d", i, retired, ret_hold);
            end
        end
        flush = 1'b1;
        tick();
        total++;
        if ({w_valid, u_if.wr, retired} !== {1'b0, 1'b0, ret_hold + 32'd1}) begin
            bad++;
            $display("FAIL flush_stall got v=%b wr=%b ret=%0d exp v=0 wr=0 ret=%0d",
                     w_valid, u_if.wr, retired, ret_hold + 32'd1);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [4:0]  dst;
        logic [31:0] val;
        logic        link;
        logic        rw;
        for (int i = 0; i < 16; i++) begin
            dst  = 5'($urandom_range(0, 31));
            val  = $urandom;
            link = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 3) != 0);
            drive(1, rw, dst, link ? SEL_LINK : SEL_ALU, 3'd0, 2'd0,
                  link ? 32'h0 : val, 32'hFFFFFFFF, link ? val : 32'h0);
            sb.push_back('{rw && (dst != 5'd0), dst, val, 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if ({u_if.wr, u_if.RegWrDst_W, u_if.wd, retired} !== {e.wr, e.dst, e.wd, exp_ret}) begin
                bad++;
                $display("FAIL b2b_%0d got wr=%b dst=%0d wd=%h ret=%0d exp wr=%b dst=%0d wd=%h ret=%0d",
                         i, u_if.wr, u_if.RegWrDst_W, u_if.wd, retired, e.wr, e.dst, e.wd, exp_ret);
            end
        end
    endtask

    task automatic test_reset_in_stall();
        drive(1, 1, 5'd9, SEL_MEM, 3'd0, 2'd0, 32'h0, 32'h11223344, 32'h0);
        tick();
        total++;
        if (w_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_stall_pre got v=%b exp v=1", w_valid);
        end
        stall = 1'b1;
        rst_n = 1'b0;
        tick();
        total++;
        if ({w_valid, u_if.wr, retired} !== {1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL rst_stall got v=%b wr=%b ret=%0d exp v=0 wr=0 ret=0",
                     w_valid, u_if.wr, retired);
        end
        rst_n = 1'b1;
        stall = 1'b0;
        drive(0, 0, 5'd0, SEL_ALU, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        mv      = 1'b0;
        exp_ret = 32'd0;
        test_reset();
        test_alu();
        test_loads();
        test_misalign();
        test_zero_and_bad();
        test_stall_jal();
        test_back_to_back();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
